// File: rtl/pport_pkg.sv
// Shared constants for the Wishbone parallel port: register map, bit positions
// and the FIFO depth clamp.
package pport_pkg;

    typedef enum logic [1:0] {
        AddrSetup  = 2'd0,
        AddrStatus = 2'd1,
        AddrRxReg  = 2'd2,
        AddrTxReg  = 2'd3
    } pport_addr_e;

    localparam int unsigned SetupLbBit = 16;
    localparam int unsigned FlagOvfBit = 15;
    // On writes this bit requests a FIFO reset; on reads it is empty (RX) or full (TX).
    localparam int unsigned FlagRstBit = 12;
    localparam int unsigned TxStbBit   = 10;
    localparam int unsigned TxBusyBit  = 9;

    localparam int unsigned LgflenMin = 2;
    localparam int unsigned LgflenMax = 10;

    function automatic int unsigned clamp_lgflen(input int unsigned lg);
        if (lg < LgflenMin) return LgflenMin;
        if (lg > LgflenMax) return LgflenMax;
        return lg;
    endfunction

endpackage

// File: rtl/pport_fifo.sv
// Synchronous FIFO of 2**LGFLEN words with soft clear. A push into a full FIFO
// completes only when a pop happens in the same cycle.
module pport_fifo
    import pport_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DW-1:0]     wdata,
    input  logic              pop,
    output logic [DW-1:0]     rdata,
    output logic              empty_n,
    output logic              full,
    output logic [LGFLEN:0]   fill
);

    localparam int unsigned Depth = 1 << LGFLEN;

    logic [DW-1:0]     mem [Depth];
    logic [LGFLEN-1:0] wr_q, rd_q;
    logic [LGFLEN:0]   fill_q;
    logic              do_push, do_pop;

    assign empty_n = (fill_q != '0);
    // fill never exceeds Depth, so the MSB alone marks full.
    assign full    = fill_q[LGFLEN];
    assign fill    = fill_q;
    assign rdata   = mem[rd_q];

    always_comb begin
        do_pop  = pop && empty_n;
        do_push = push && (!full || do_pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || clr) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_q] <= wdata;
    end

endmodule

// File: rtl/wb_pport_ng.sv
// Wishbone-attached parallel port with RX/TX FIFOs and RX idle timeout.
// Optional internal TX->RX loopback when WB_PPORT_NG_LOOPBACK_EN is defined.
module wb_pport_ng
    import pport_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned LGFLEN   = 4,
    parameter logic [15:0] DEF_RXTO = 16'd64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [1:0]    i_wb_addr,
    input  logic [31:0]   i_wb_data,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic [31:0]   o_wb_data,
    input  logic          i_pp_stb,
    input  logic [DW-1:0] i_pp_data,
    output logic          o_pp_stb,
    output logic [DW-1:0] o_pp_data,
    input  logic          i_pp_busy,
    output logic          o_rx_int,
    output logic          o_rxfifo_int,
    output logic          o_rxto_int,
    output logic          o_tx_int,
    output logic          o_txfifo_int
);

    localparam int unsigned Lgf = clamp_lgflen(LGFLEN);

    logic          wb_acc, wb_wr, wb_rd, setup_wr;
    logic          rx_rd, tx_rd, lb;
    logic          rx_push, rx_pop, rx_clr, rx_empty_n, rx_full, rx_drop;
    logic          tx_push, tx_pop, tx_clr, tx_empty_n, tx_full, tx_drop;
    logic [DW-1:0] rx_wdata, rx_head, tx_head;
    logic [Lgf:0]  rx_fill, tx_fill;
    logic [31:0]   rd_d, rd_q;
    logic [1:0]    ack_q;
    logic [15:0]   rxto_q, to_cnt_q;
    logic          rx_ovf_q, tx_ovf_q, rxto_int_q, to_run;
    logic          unused_wb;

    assign unused_wb = ^i_wb_data;

    assign wb_acc   = i_wb_cyc && i_wb_stb;
    assign wb_wr    = wb_acc && i_wb_we;
    assign wb_rd    = wb_acc && !i_wb_we;
    assign setup_wr = wb_wr && (i_wb_addr == AddrSetup);
    assign rx_rd    = wb_rd && (i_wb_addr == AddrRxReg);
    assign tx_rd    = wb_rd && (i_wb_addr == AddrTxReg);

`ifdef WB_PPORT_NG_LOOPBACK_EN
    logic lb_q;
    always_ff @(posedge i_clk) begin
        if (i_rst)         lb_q <= 1'b0;
        else if (setup_wr) lb_q <= i_wb_data[SetupLbBit];
    end
    assign lb = lb_q;
`else
    assign lb = 1'b0;
`endif

    // In loopback the TX FIFO drains one word per cycle straight into RX.
    assign tx_pop   = tx_empty_n && (lb || !i_pp_busy);
    assign tx_push  = wb_wr && (i_wb_addr == AddrTxReg) && !i_wb_data[FlagRstBit];
    assign tx_clr   = setup_wr || (wb_wr && (i_wb_addr == AddrTxReg) && i_wb_data[FlagRstBit]);
    assign tx_drop  = tx_push && tx_full && !tx_pop && !tx_clr;

    assign rx_push  = lb ? tx_pop : i_pp_stb;
    assign rx_wdata = lb ? tx_head : i_pp_data;
    assign rx_pop   = rx_rd && rx_empty_n;
    assign rx_clr   = setup_wr || (wb_wr && (i_wb_addr == AddrRxReg) && i_wb_data[FlagRstBit]);
    assign rx_drop  = rx_push && rx_full && !rx_pop && !rx_clr;

    pport_fifo #(.DW(DW), .LGFLEN(Lgf)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clr     (rx_clr),
        .push    (rx_push),
        .wdata   (rx_wdata),
        .pop     (rx_pop),
        .rdata   (rx_head),
        .empty_n (rx_empty_n),
        .full    (rx_full),
        .fill    (rx_fill)
    );

    pport_fifo #(.DW(DW), .LGFLEN(Lgf)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clr     (tx_clr),
        .push    (tx_push),
        .wdata   (i_wb_data[DW-1:0]),
        .pop     (tx_pop),
        .rdata   (tx_head),
        .empty_n (tx_empty_n),
        .full    (tx_full),
        .fill    (tx_fill)
    );

    assign o_wb_stall   = 1'b0;
    assign o_wb_ack     = ack_q[1] && i_wb_cyc;
    assign o_pp_stb     = tx_empty_n && !lb;
    assign o_pp_data    = tx_head;
    assign o_rx_int     = rx_empty_n;
    assign o_rxfifo_int = rx_fill[Lgf] || rx_fill[Lgf-1];
    assign o_rxto_int   = rxto_int_q;
    assign o_tx_int     = !tx_full;
    assign o_txfifo_int = !(tx_fill[Lgf] || tx_fill[Lgf-1]);

    always_comb begin
        rd_d = '0;
        unique case (i_wb_addr)
            AddrSetup: begin
                rd_d[31:28]      = 4'(Lgf);
                rd_d[27:24]      = 4'(DW);
                rd_d[SetupLbBit] = lb;
                rd_d[15:0]       = rxto_q;
            end
            AddrStatus: rd_d = {16'(tx_fill), 16'(rx_fill)};
            AddrRxReg: begin
                rd_d[FlagOvfBit] = rx_ovf_q;
                rd_d[FlagRstBit] = !rx_empty_n;
                rd_d[11:0]       = 12'(rx_head);
            end
            AddrTxReg: begin
                rd_d[FlagOvfBit] = tx_ovf_q;
                rd_d[FlagRstBit] = tx_full;
                rd_d[TxStbBit]   = o_pp_stb;
                rd_d[TxBusyBit]  = i_pp_busy;
            end
            default: rd_d = '0;
        endcase
    end

    assign to_run = rx_empty_n && (rxto_q != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q      <= '0;
            rd_q       <= '0;
            o_wb_data  <= '0;
            rxto_q     <= DEF_RXTO;
            rx_ovf_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            to_cnt_q   <= '0;
            rxto_int_q <= 1'b0;
        end else begin
            ack_q     <= {ack_q[0], wb_acc};
            o_wb_data <= rd_q;
            if (wb_acc)   rd_q   <= rd_d;
            if (setup_wr) rxto_q <= i_wb_data[15:0];

            if (setup_wr)     rx_ovf_q <= 1'b0;
            else if (rx_drop) rx_ovf_q <= 1'b1;
            else if (rx_rd)   rx_ovf_q <= 1'b0;

            if (setup_wr)     tx_ovf_q <= 1'b0;
            else if (tx_drop) tx_ovf_q <= 1'b1;
            else if (tx_rd)   tx_ovf_q <= 1'b0;

            // Counter saturates at rxto so the interrupt fires once per idle period.
            if (rx_clr || rx_push || !to_run) to_cnt_q <= '0;
            else if (to_cnt_q != rxto_q)      to_cnt_q <= to_cnt_q + 16'd1;

            if (rx_clr || rx_push || rx_rd) begin
                rxto_int_q <= 1'b0;
            end else if (to_run && (to_cnt_q != rxto_q) && (to_cnt_q + 16'd1 == rxto_q)) begin
                rxto_int_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_pport_ng.sv
// Self-checking bench for wb_pport_ng: directed register/timing cases followed by
// randomized traffic compared against a queue-based model of the port.
module tb_wb_pport_ng;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_stall, wb_ack;
    logic [31:0] wb_rdata;
    logic        pp_stb_in;
    logic [7:0]  pp_data_in;
    logic        pp_stb_out;
    logic [7:0]  pp_data_out;
    logic        pp_busy;
    logic        rx_int, rxfifo_int, rxto_int, tx_int, txfifo_int;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_pport_ng #(.DW(8), .LGFLEN(4), .DEF_RXTO(16'd64)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wb_cyc     (wb_cyc),
        .i_wb_stb     (wb_stb),
        .i_wb_we      (wb_we),
        .i_wb_addr    (wb_addr),
        .i_wb_data    (wb_wdata),
        .o_wb_stall   (wb_stall),
        .o_wb_ack     (wb_ack),
        .o_wb_data    (wb_rdata),
        .i_pp_stb     (pp_stb_in),
        .i_pp_data    (pp_data_in),
        .o_pp_stb     (pp_stb_out),
        .o_pp_data    (pp_data_out),
        .i_pp_busy    (pp_busy),
        .o_rx_int     (rx_int),
        .o_rxfifo_int (rxfifo_int),
        .o_rxto_int   (rxto_int),
        .o_tx_int     (tx_int),
        .o_txfifo_int (txfifo_int)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One single-beat transaction; ack must be low one cycle after accept, high the next.
    task automatic wb_op(input logic we, input logic [1:0] addr, input logic [31:0] data,
                         output logic [31:0] rdata);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = data;
        @(negedge clk);
        wb_stb = 1'b0;
        check_eq("ack_early", {31'd0, wb_ack}, 32'd0);
        @(negedge clk);
        check_eq("ack_2cyc", {31'd0, wb_ack}, 32'd1);
        rdata = wb_rdata;
        wb_cyc = 1'b0;
    endtask

    // Transfer monitor for the TXREG 0x5A burst.
    bit mon_en = 1'b0;
    int mon_cnt = 0;
    int mon_bad = 0;
    always @(negedge clk) begin
        if (mon_en && pp_stb_out && !pp_busy) begin
            mon_cnt++;
            if (pp_data_out != 8'h5A) mon_bad++;
        end
    end

    // Reference model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic        rx_ovf_m, tx_ovf_m;
    logic [15:0] rxto_m;

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"}, {31'd0, wb_ack}, 32'd0);
        check_eq({tag, "_ppstb"}, {31'd0, pp_stb_out}, 32'd0);
        check_eq({tag, "_ints"}, {27'd0, rx_int, rxfifo_int, rxto_int, tx_int, txfifo_int},
                 32'b00011);
        check_eq({tag, "_stall"}, {31'd0, wb_stall}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] pd[2], pm[2];
        bit          pv[2], pr[2];

        rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = 0; wb_wdata = 0;
        pp_stb_in = 0; pp_data_in = 0; pp_busy = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        wb_op(1'b0, 2'd0, 32'd0, rd);
        check_eq("setup_rst", rd, 32'h4800_0040);
        wb_op(1'b0, 2'd1, 32'd0, rd);
        check_eq("status_rst", rd, 32'd0);

        // TXREG 0x5A x3, sink always ready
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) wb_op(1'b1, 2'd3, 32'h5A, rd);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check_eq("tx5a_count", mon_cnt, 3);
        check_eq("tx5a_data", mon_bad, 0);

        // 17 RX pushes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            pp_stb_in = 1'b1; pp_data_in = 8'h10 + 8'(i);
        end
        @(negedge clk);
        pp_stb_in = 1'b0;
        check_eq("rx_full_ints", {30'd0, rx_int, rxfifo_int}, 32'b11);
        wb_op(1'b0, 2'd1, 32'd0, rd);
        check_eq("rx_fill16", rd, 32'h0000_0010);
        wb_op(1'b0, 2'd2, 32'd0, rd);
        check_eq("rx_ovf_read", rd, 32'h0000_8010);
        wb_op(1'b0, 2'd2, 32'd0, rd);
        check_eq("rx_ovf_clr", rd, 32'h0000_0011);

        // Empty RX read: flag set, no underflow
        wb_op(1'b1, 2'd2, 32'h1000, rd);
        wb_op(1'b0, 2'd2, 32'd0, rd);
        check_eq("rx_empty_flags", rd & 32'hFFFF_F000, 32'h0000_1000);
        wb_op(1'b0, 2'd1, 32'd0, rd);
        check_eq("rx_empty_fill", rd, 32'd0);

        // RX idle timeout of 10 cycles
        wb_op(1'b1, 2'd0, 32'd10, rd);
        @(negedge clk);
        pp_stb_in = 1'b1; pp_data_in = 8'hC3;
        @(negedge clk);
        pp_stb_in = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("rxto_early", {31'd0, rxto_int}, 32'd0);
        @(negedge clk);
        check_eq("rxto_fire", {31'd0, rxto_int}, 32'd1);
        wb_op(1'b0, 2'd2, 32'd0, rd);
        check_eq("rxto_data", rd, 32'h0000_00C3);
        check_eq("rxto_clr", {31'd0, rxto_int}, 32'd0);

        // TX overflow with a stalled sink, then in-order drain
        pp_busy = 1'b1;
        for (int i = 0; i < 17; i++) wb_op(1'b1, 2'd3, 32'(i), rd);
        check_eq("tx_full_ints", {30'd0, tx_int, txfifo_int}, 32'b00);
        wb_op(1'b0, 2'd3, 32'd0, rd);
        check_eq("tx_ovf_read", rd, 32'h0000_9600);
        wb_op(1'b0, 2'd3, 32'd0, rd);
        check_eq("tx_ovf_clr", rd, 32'h0000_1600);
        @(negedge clk);
        check_eq("tx_hold", {24'd0, pp_data_out}, 32'd0);
        pp_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_eq("tx_drain", {23'd0, pp_stb_out, pp_data_out}, {23'd0, 1'b1, 8'(i)});
            @(negedge clk);
        end
        check_eq("tx_drained", {31'd0, pp_stb_out}, 32'd0);

`ifdef WB_PPORT_NG_LOOPBACK_EN
        wb_op(1'b1, 2'd0, 32'h0001_0040, rd);
        wb_op(1'b0, 2'd0, 32'd0, rd);
        check_eq("lb_setup", rd, 32'h4801_0040);
        wb_op(1'b1, 2'd3, 32'h33, rd);
        check_eq("lb_ppstb", {31'd0, pp_stb_out}, 32'd0);
        wb_op(1'b0, 2'd2, 32'd0, rd);
        check_eq("lb_rx", rd, 32'h0000_0033);
        check_eq("lb_ppstb2", {31'd0, pp_stb_out}, 32'd0);
        wb_op(1'b1, 2'd0, 32'h0000_0040, rd);
`endif

        // Randomized traffic against the queue model
        wb_op(1'b1, 2'd0, 32'h0000_0040, rd);
        rxq.delete(); txq.delete();
        rx_ovf_m = 1'b0; tx_ovf_m = 1'b0; rxto_m = 16'h0040;
        pv = '{0, 0}; pr = '{0, 0};
        wb_cyc = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit          hi, stb, we, tx_pop_m, tx_full_pre, rx_pop_m, rx_full_pre;
            logic [1:0]  addr;
            logic [31:0] d, exp_rd, mask;
            int          op;

            @(negedge clk);
            check_eq("rnd_ppstb", {31'd0, pp_stb_out}, {31'd0, txq.size() != 0});
            if (txq.size() != 0) check_eq("rnd_ppdata", {24'd0, pp_data_out}, {24'd0, txq[0]});
            check_eq("rnd_ints", {28'd0, rx_int, rxfifo_int, tx_int, txfifo_int},
                     {28'd0, rxq.size() != 0, rxq.size() >= 8, txq.size() < 16, txq.size() < 8});
            check_eq("rnd_ack", {31'd0, wb_ack}, {31'd0, pv[1]});
            if (pv[1] && pr[1]) check_eq("rnd_rdata", wb_rdata & pm[1], pd[1] & pm[1]);
            pv[1] = pv[0]; pr[1] = pr[0]; pd[1] = pd[0]; pm[1] = pm[0];

            hi = ((cyc / 400) % 2) == 0;
            pp_stb_in  = $urandom_range(0, 99) < (hi ? 70 : 10);
            pp_data_in = 8'($urandom);
            pp_busy    = $urandom_range(0, 99) < (hi ? 95 : 10);
            stb = $urandom_range(0, 99) < 45;
            op  = $urandom_range(0, 99);
            d   = $urandom;
            if      (op < 30) begin we = 0; addr = 2'd2; end
            else if (op < 55) begin we = 1; addr = 2'd3; d[12] = 1'b0; end
            else if (op < 65) begin we = 0; addr = 2'd1; end
            else if (op < 75) begin we = 0; addr = 2'd3; end
            else if (op < 82) begin we = 0; addr = 2'd0; end
            else if (op < 88) begin we = 1; addr = 2'd2; end
            else if (op < 93) begin we = 1; addr = 2'd3; d[12] = 1'b1; end
            else if (op < 96) begin we = 1; addr = 2'd0; d = d & 32'h0000_FFFF; end
            else              begin we = 1; addr = 2'd1; end

            mask = 32'hFFFF_FFFF;
            case (addr)
                2'd0: exp_rd = {4'd4, 4'd8, 7'd0, 1'b0, rxto_m};
                2'd1: exp_rd = {16'(txq.size()), 16'(rxq.size())};
                2'd2: begin
                    exp_rd = {16'd0, rx_ovf_m, 2'b0, rxq.size() == 0, 4'd0,
                              (rxq.size() != 0) ? rxq[0] : 8'h00};
                    if (rxq.size() == 0) mask = 32'hFFFF_FF00;
                end
                default: exp_rd = {16'd0, tx_ovf_m, 2'b0, txq.size() == 16, 1'b0,
                                   txq.size() != 0, pp_busy, 9'd0};
            endcase
            pv[0] = stb; pr[0] = stb && !we; pd[0] = exp_rd; pm[0] = mask;
            wb_stb = stb; wb_we = we; wb_addr = addr; wb_wdata = d;

            tx_full_pre = txq.size() == 16;
            tx_pop_m    = (txq.size() != 0) && !pp_busy;
            if (tx_pop_m) void'(txq.pop_front());
            if (stb && we && addr == 2'd0) begin
                txq.delete(); rxq.delete();
                tx_ovf_m = 1'b0; rx_ovf_m = 1'b0; rxto_m = d[15:0];
            end else begin
                if (stb && we && addr == 2'd3) begin
                    if (d[12]) txq.delete();
                    else if (!tx_full_pre || tx_pop_m) txq.push_back(d[7:0]);
                    else tx_ovf_m = 1'b1;
                end
                if (stb && !we && addr == 2'd3) tx_ovf_m = 1'b0;
                rx_full_pre = rxq.size() == 16;
                rx_pop_m    = stb && !we && addr == 2'd2 && rxq.size() != 0;
                if (rx_pop_m) void'(rxq.pop_front());
                if (stb && !we && addr == 2'd2) rx_ovf_m = 1'b0;
                if (stb && we && addr == 2'd2 && d[12]) rxq.delete();
                else if (pp_stb_in) begin
                    if (!rx_full_pre || rx_pop_m) rxq.push_back(pp_data_in);
                    else rx_ovf_m = 1'b1;
                end
            end
        end
        @(negedge clk);
        wb_stb = 1'b0; wb_cyc = 1'b0; pp_stb_in = 1'b0;
        check_eq("rnd_last_ack", {31'd0, wb_ack}, {31'd0, pv[1]});

        // Reset while a read is outstanding: the ack must never arrive
        pp_busy = 1'b1;
        wb_op(1'b1, 2'd3, 32'h11, rd);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 2'd1;
        @(negedge clk);
        wb_stb = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_no_ack", {31'd0, wb_ack}, 32'd0);
        wb_cyc = 1'b0;
        pp_busy = 1'b0;
        wb_op(1'b0, 2'd0, 32'd0, rd);
        check_eq("rst_setup", rd, 32'h4800_0040);
        wb_op(1'b0, 2'd1, 32'd0, rd);
        check_eq("rst_status", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_pport_ng.md
WB_PPORT_NG -- requirements
Module: wb_pport_ng

Interface
REQ-001 SHALL have parameter DW, default 8: parallel data width, legal 1..12.
REQ-002 SHALL have parameter LGFLEN, default 4: log2 FIFO depth, clamped to 2..10.
REQ-003 SHALL have parameter DEF_RXTO, default 16'd64: reset value of the RX idle-timeout register.
REQ-004 SHALL have ports, clock and reset first: i_clk in 1, system clock; i_rst in 1, reset.
REQ-005 SHALL have Wishbone ports: i_wb_cyc, i_wb_stb, i_wb_we in 1 each; i_wb_addr in 2; i_wb_data in 32; o_wb_stall out 1; o_wb_ack out 1; o_wb_data out 32.
REQ-006 SHALL have RX ports: i_pp_stb in 1, word valid; i_pp_data in DW, word.
REQ-007 SHALL have TX ports: o_pp_stb out 1, word valid; o_pp_data out DW, word; i_pp_busy in 1, sink busy.
REQ-008 SHALL have interrupt ports, all out 1: o_rx_int, o_rxfifo_int, o_rxto_int, o_tx_int, o_txfifo_int.
REQ-009 SHALL use one clock, i_clk; i_rst SHALL be synchronous and active-high.

Function
REQ-010 SHALL assign addresses: 0 SETUP, 1 FIFO status, 2 RXREG, 3 TXREG.
REQ-011 SHALL hold o_wb_stall at 0 and assert o_wb_ack exactly 2 cycles after each accepted stb, gated by i_wb_cyc on the ack cycle.
REQ-012 SHALL read SETUP as {LGFLEN[3:0], DW[3:0], 7'b0, loopback, rxto[15:0]}.
REQ-013 SHALL, on a SETUP write, load rxto from data[15:0] and loopback from data[16], and reset both FIFOs and all sticky flags.
REQ-014 SHALL read FIFO status as {tx fill count[15:0], rx fill count[15:0]}, zero-extended.
REQ-015 SHALL read RXREG as {16'b0, rx_ovf, 2'b0, rx_empty, zero-padded data[11:0]}, and pop one word only if the FIFO is non-empty.
REQ-016 SHALL clear rx_ovf on an RXREG read and reset the RX FIFO on an RXREG write with data[12]=1.
REQ-017 SHALL push data[DW-1:0] on a TXREG write with data[12]=0; with data[12]=1 it SHALL reset the TX FIFO instead of pushing.
REQ-018 SHALL read TXREG as {16'b0, tx_ovf, 2'b0, tx_full, 1'b0, o_pp_stb, i_pp_busy, 9'b0}; the read SHALL clear tx_ovf.
REQ-019 SHALL drop pushes to a full FIFO and set the matching sticky ovf flag; a push and a pop in the same cycle on a full FIFO SHALL both complete.
REQ-020 SHALL drive o_pp_stb = TX non-empty; a word transfers on a cycle with o_pp_stb && !i_pp_busy; o_pp_data SHALL hold while stalled.
REQ-021 SHALL push i_pp_data into the RX FIFO on each i_pp_stb cycle.
REQ-022 SHALL count cycles since the last RX push while RX is non-empty and rxto!=0; when the count equals rxto it SHALL set o_rxto_int.
REQ-023 SHALL clear o_rxto_int on an RXREG read, an RX reset, or a new RX push.
REQ-024 SHALL set o_rx_int = RX non-empty, o_rxfifo_int = RX at least half full, o_tx_int = TX not full, o_txfifo_int = TX less than half full.
REQ-025 SHALL let the FIFO pointers wrap modulo 2**LGFLEN, with fill counts covering 0..2**LGFLEN.

Reset
REQ-026 SHALL, on i_rst, set: both FIFOs empty, sticky flags 0, rxto=DEF_RXTO, loopback=0, o_wb_ack=0, o_pp_stb=0, o_rxto_int=0, and the timeout counter 0.
REQ-027 SHALL discard any pending ack when reset occurs mid-transaction.

Configuration
REQ-028 SHALL, with WB_PPORT_NG_LOOPBACK_EN defined and loopback=1, route TX pops into the RX FIFO at one per cycle, ignore i_pp_stb and i_pp_busy, and hold o_pp_stb at 0.
REQ-029 SHALL, without WB_PPORT_NG_LOOPBACK_EN, ignore SETUP data[16] and read the loopback bit as 0.

Structure
REQ-030 SHALL place the register address constants, SETUP and status bit positions, and the LGFLEN clamp limits in shared package pport_pkg.
REQ-031 SHALL instantiate one sub-module, pport_fifo (parameters DW and LGFLEN; outputs empty_n, full, fill), twice: once for RX and once for TX.

Verification
REQ-032 Write TXREG 0x5A x3 with i_pp_busy=0 -> o_pp_data 0x5A on 3 transfer cycles; each ack arrives 2 cycles after its stb.
REQ-033 Push 17 RX words with LGFLEN=4 -> fill=16, RXREG bit15=1; the following read returns the first word and clears bit15.
REQ-034 SETUP rxto=10, one i_pp_stb -> o_rxto_int high at cycle 10; an RXREG read clears it.
REQ-035 Read an empty RXREG -> bit12=1, fill stays 0, no underflow.
REQ-036 With the macro defined, loopback=1, and TXREG 0x33 written -> RXREG returns 0x33 and o_pp_stb stays 0.
REQ-037 Assert i_rst during an outstanding read -> no ack follows, and all outputs match REQ-026.
